// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: IV, FSM encoding, working-variable bundle
// and the four round/schedule mixing functions.
package sha256_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Same layout as H: a lands in [255:224] like H0.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } wv_t;

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round constant table K[0..63].
// Purely combinational lookup.
module sha256_k_rom (
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k = K_TAB[idx];

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: feeds message words into an external
// W schedule memory and runs one round per cycle on its W stream.
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         INIT,
  input  logic [31:0]  MSG_DATA,
  input  logic         MSG_VALID,
  output logic         MSG_READY,
  output logic [5:0]   W_I,
  output logic [31:0]  W_D,
  input  logic [31:0]  W_Q,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [255:0] H_OUT
);

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  logic [1:0]   state_q, state_d;
  logic [5:0]   r_q, r_d;
  wv_t          wv_q, wv_d;
  logic [255:0] h_q, h_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [31:0]  k;
  logic [31:0]  t1;
  logic [31:0]  t2;
  logic [255:0] wv_vec;

  sha256_k_rom u_k_rom (
    .idx (r_q),
    .k   (k)
  );

  assign MSG_READY = (state_q == ST_ROUND) && (r_q < 6'd16);
  assign W_D       = MSG_READY ? MSG_DATA : 32'h0;
  assign W_I       = r_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign H_OUT     = h_q;
  assign wv_vec    = wv_q;

  assign t1 = wv_q.h + big_sigma1(wv_q.e)
            + ch(wv_q.e, wv_q.f, wv_q.g) + k + W_Q;
  assign t2 = big_sigma0(wv_q.a) + maj(wv_q.a, wv_q.b, wv_q.c);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    wv_d    = wv_q;
    h_d     = h_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        r_d = 6'd0;
        if (START) begin
          h_d     = INIT ? IV : h_q;
          wv_d    = INIT ? IV : h_q;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (MSG_READY && !MSG_VALID) begin
          // Underrun: drop the block, leave a..h and H untouched.
          state_d = ST_IDLE;
          r_d     = 6'd0;
          err_d   = 1'b1;
        end else begin
          wv_d.h = wv_q.g;
          wv_d.g = wv_q.f;
          wv_d.f = wv_q.e;
          wv_d.e = wv_q.d + t1;
          wv_d.d = wv_q.c;
          wv_d.c = wv_q.b;
          wv_d.b = wv_q.a;
          wv_d.a = t1 + t2;
          if (r_q == LAST) begin
            state_d = ST_FINAL;
          end else begin
            r_d = r_q + 6'd1;
          end
        end
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_d[32*i +: 32] = h_q[32*i +: 32] + wv_vec[32*i +: 32];
        end
        r_d     = 6'd0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        r_d     = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      r_q     <= 6'd0;
      wv_q    <= '0;
      h_q     <= IV;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      wv_q    <= wv_d;
      h_q     <= h_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
